// File: rtl/datapath_pipe_pkg.sv
`default_nettype none
// ============================================================================
// datapath_pipe_pkg : opcodes, shift modes and the W-stage record
// Revision : 1.0
// ============================================================================
package datapath_pipe_pkg;

    // Widest datapath/address the W-stage record can carry; narrower
    // instances zero-extend into it.
    localparam int MAX_WIDTH = 64;
    localparam int MAX_AW    = 8;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_OR    = 3'b011;
    localparam logic [2:0] OP_XOR   = 3'b100;
    localparam logic [2:0] OP_PASSA = 3'b101;
    localparam logic [2:0] OP_NOTA  = 3'b110;
    localparam logic [2:0] OP_PASSB = 3'b111;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROL = 2'b11;

    typedef struct packed {
        logic                 valid;
        logic                 we;
        logic                 oe;
        logic [MAX_AW-1:0]    addr_wr;
        logic [MAX_WIDTH-1:0] result;
        logic                 z;
        logic                 c;
    } w_stage_t;

endpackage
`default_nettype wire

// File: rtl/datapath_pipe_if.sv
`default_nettype none
// ============================================================================
// datapath_pipe_if : instruction and result handshake bundle
// Revision : 1.0
// ============================================================================
interface datapath_pipe_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
);
    localparam int AW  = $clog2(NREGS);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic             ie;
    logic             we;
    logic             oe;
    logic [AW-1:0]    addr_wr;
    logic [AW-1:0]    addr_rda;
    logic [AW-1:0]    addr_rdb;
    logic [2:0]       opcode;
    logic [1:0]       sh_mode;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] inport;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] outport;
    logic             flag_z;
    logic             flag_c;

    modport master (
        output in_valid, ie, we, oe, addr_wr, addr_rda, addr_rdb,
               opcode, sh_mode, shamt, inport, out_ready,
        input  in_ready, out_valid, outport, flag_z, flag_c
    );

    modport slave (
        input  in_valid, ie, we, oe, addr_wr, addr_rda, addr_rdb,
               opcode, sh_mode, shamt, inport, out_ready,
        output in_ready, out_valid, outport, flag_z, flag_c
    );
endinterface
`default_nettype wire

// File: rtl/dp_shifter.sv
`default_nettype none
// ============================================================================
// dp_shifter : combinational barrel shifter (SLL / SRL / SRA / ROL)
// Revision : 1.0
// ============================================================================
module dp_shifter
    import datapath_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    input  logic [SHW-1:0]   shamt,
    output logic [WIDTH-1:0] dout
);
    logic [SHW-1:0]     w_rot;
    logic [2*WIDTH-1:0] w_dd;

    // Rotation wraps modulo WIDTH; only matters for non-power-of-two WIDTH.
    assign w_rot = SHW'(32'(shamt) % WIDTH);
    assign w_dd  = {din, din} << w_rot;

    always_comb begin
        dout = din;
        case (mode)
            SH_SLL:  dout = din << shamt;
            SH_SRL:  dout = din >> shamt;
            SH_SRA:  dout = $unsigned($signed(din) >>> shamt);
            default: dout = w_dd[2*WIDTH-1:WIDTH];
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/datapath_pipe.sv
`default_nettype none
// ============================================================================
// datapath_pipe : two-stage regfile / ALU / shifter datapath with outport
// Revision : 1.0
// ============================================================================
module datapath_pipe
    import datapath_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic            CLK,
    input  logic            RST_N,
    datapath_pipe_if.slave  bus
);
    localparam int AW  = $clog2(NREGS);
    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] r_regs [NREGS];
    w_stage_t         r_w;
    w_stage_t         w_next;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_outport;
    logic             r_flag_z;
    logic             r_flag_c;

    logic [WIDTH-1:0] w_res_w;
    logic [WIDTH-1:0] w_opa;
    logic [WIDTH-1:0] w_opb;
    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH-1:0] w_alu;
    logic             w_carry;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_result;
    logic             w_retire;
    logic             w_accept;
    logic             w_unused_hi;

    assign w_res_w     = r_w.result[WIDTH-1:0];
    assign w_unused_hi = ^r_w.result;

    // Bypass: an older instruction sitting in W always wins over the array.
    assign w_opa = (r_w.valid && r_w.we && r_w.addr_wr == MAX_AW'(bus.addr_rda))
                   ? w_res_w : r_regs[bus.addr_rda];
    assign w_opb = (r_w.valid && r_w.we && r_w.addr_wr == MAX_AW'(bus.addr_rdb))
                   ? w_res_w : r_regs[bus.addr_rdb];

    assign w_add = {1'b0, w_opa} + {1'b0, w_opb};
    assign w_sub = {1'b0, w_opa} - {1'b0, w_opb};

    always_comb begin
        w_alu   = '0;
        w_carry = 1'b0;
        case (bus.opcode)
            OP_ADD:   begin w_alu = w_add[WIDTH-1:0]; w_carry = w_add[WIDTH]; end
            OP_SUB:   begin w_alu = w_sub[WIDTH-1:0]; w_carry = w_sub[WIDTH]; end
            OP_AND:   w_alu = w_opa & w_opb;
            OP_OR:    w_alu = w_opa | w_opb;
            OP_XOR:   w_alu = w_opa ^ w_opb;
            OP_PASSA: w_alu = w_opa;
            OP_NOTA:  w_alu = ~w_opa;
            default:  w_alu = w_opb;
        endcase
    end

    dp_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .din   (w_alu),
        .mode  (bus.sh_mode),
        .shamt (bus.shamt),
        .dout  (w_shift)
    );

    assign w_result = bus.ie ? bus.inport : w_shift;

    always_comb begin
        w_next         = '0;
        w_next.valid   = 1'b1;
        w_next.we      = bus.we;
        w_next.oe      = bus.oe;
        w_next.addr_wr = MAX_AW'(bus.addr_wr);
        w_next.result  = MAX_WIDTH'(w_result);
        w_next.z       = (w_result == '0);
        w_next.c       = w_carry & ~bus.ie;
    end

    assign w_retire     = r_w.valid & (~r_w.oe | ~r_out_valid | bus.out_ready);
    assign bus.in_ready = ~r_w.valid | w_retire;
    assign w_accept     = bus.in_valid & bus.in_ready;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_w         <= '0;
            r_out_valid <= 1'b0;
            r_outport   <= '0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (w_retire && r_w.we) begin
                r_regs[r_w.addr_wr[AW-1:0]] <= w_res_w;
            end
            // A fresh oe retire keeps out_valid high even while the old value drains.
            if (w_retire && r_w.oe) begin
                r_outport   <= w_res_w;
                r_flag_z    <= r_w.z;
                r_flag_c    <= r_w.c;
                r_out_valid <= 1'b1;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_w <= w_next;
            end else if (w_retire) begin
                r_w.valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.outport   = r_outport;
    assign bus.flag_z    = r_flag_z;
    assign bus.flag_c    = r_flag_c;

endmodule
`default_nettype wire

// File: tb/tb_datapath_pipe.sv
`default_nettype none
// ============================================================================
// tb_datapath_pipe : vector table + scoreboard bench for datapath_pipe
// Revision : 1.0
// ============================================================================
module tb_datapath_pipe;
    import datapath_pipe_pkg::*;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;

    typedef struct {
        logic        ie, we, oe;
        logic [2:0]  wr, ra, rb, op;
        logic [1:0]  mode;
        logic [3:0]  sh;
        logic [15:0] inport;
        logic [15:0] exp;
        logic        ez, ec;
    } vec_t;

    typedef struct packed {
        logic [15:0] d;
        logic        z;
        logic        c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    exp_t sb [$];
    vec_t vecs [24];

    datapath_pipe_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

    datapath_pipe #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ie, we, oe, input logic [2:0] wr, ra, rb, op,
                                input logic [1:0] mode, input logic [3:0] sh,
                                input logic [15:0] inp, ex, input logic ez, ec);
        vec_t v;
        v.ie = ie; v.we = we; v.oe = oe; v.wr = wr; v.ra = ra; v.rb = rb; v.op = op;
        v.mode = mode; v.sh = sh; v.inport = inp; v.exp = ex; v.ez = ez; v.ec = ec;
        return v;
    endfunction

    function automatic vec_t ld(input logic [2:0] wr, input logic [15:0] val);
        return mk(1, 1, 0, wr, 0, 0, OP_ADD, SH_SLL, 0, val, 0, 0, 0);
    endfunction

    function automatic vec_t alu(input logic [2:0] ra, rb, op, input logic [1:0] mode,
                                 input logic [3:0] sh, input logic [15:0] ex,
                                 input logic ez, ec);
        return mk(0, 0, 1, 0, ra, rb, op, mode, sh, 0, ex, ez, ec);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input vec_t v, input bit push, output int waits);
        bit acc;
        bus.in_valid = 1'b1;
        bus.ie = v.ie;  bus.we = v.we;  bus.oe = v.oe;
        bus.addr_wr = v.wr;  bus.addr_rda = v.ra;  bus.addr_rdb = v.rb;
        bus.opcode = v.op;  bus.sh_mode = v.mode;  bus.shamt = v.sh;  bus.inport = v.inport;
        waits = 0;
        acc   = 1'b0;
        while (!acc && waits < 40) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (!acc) waits++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stayed low for %0d cycles", waits);
        end else if (push && v.oe) begin
            sb.push_back('{d: v.exp, z: v.ez, c: v.ec});
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %h, none expected", bus.outport);
                end else begin
                    e = sb.pop_front();
                    check("sb_outport", bus.outport, e.d);
                    check("sb_flag_z", bus.flag_z, e.z);
                    check("sb_flag_c", bus.flag_c, e.c);
                end
            end
        end
    endtask

    initial begin
        int w;
        vecs[0]  = ld(4, 16'hFFFF);
        vecs[1]  = ld(5, 16'h0001);
        vecs[2]  = alu(4, 5, OP_ADD,   SH_SLL, 0,  16'h0000, 1, 1);
        vecs[3]  = ld(4, 16'h0002);
        vecs[4]  = ld(5, 16'h0003);
        vecs[5]  = alu(4, 5, OP_SUB,   SH_SLL, 0,  16'hFFFF, 0, 1);
        vecs[6]  = ld(7, 16'h8001);
        vecs[7]  = alu(7, 0, OP_PASSA, SH_SLL, 4,  16'h0010, 0, 0);
        vecs[8]  = alu(7, 0, OP_PASSA, SH_SRL, 4,  16'h0800, 0, 0);
        vecs[9]  = alu(7, 0, OP_PASSA, SH_SRA, 4,  16'hF800, 0, 0);
        vecs[10] = alu(7, 0, OP_PASSA, SH_ROL, 4,  16'h0018, 0, 0);
        vecs[11] = alu(4, 5, OP_AND,   SH_SLL, 0,  16'h0002, 0, 0);
        vecs[12] = alu(4, 5, OP_OR,    SH_SLL, 0,  16'h0003, 0, 0);
        vecs[13] = alu(4, 5, OP_XOR,   SH_SLL, 0,  16'h0001, 0, 0);
        vecs[14] = alu(4, 5, OP_NOTA,  SH_SLL, 0,  16'hFFFD, 0, 0);
        vecs[15] = alu(4, 5, OP_PASSB, SH_SLL, 0,  16'h0003, 0, 0);
        vecs[16] = alu(5, 5, OP_SUB,   SH_SLL, 0,  16'h0000, 1, 0);
        vecs[17] = mk(1, 0, 1, 0, 7, 7, OP_ADD, SH_SLL, 0, 16'h0000, 16'h0000, 1, 0);
        vecs[18] = mk(0, 1, 1, 3, 1, 3, OP_ADD, SH_SLL, 0, 16'h0000, 16'h0015, 0, 0);
        vecs[19] = alu(3, 0, OP_PASSA, SH_SLL, 0,  16'h0015, 0, 0);
        vecs[20] = alu(7, 0, OP_PASSA, SH_ROL, 0,  16'h8001, 0, 0);
        vecs[21] = alu(7, 0, OP_PASSA, SH_SRA, 15, 16'hFFFF, 0, 0);
        vecs[22] = alu(7, 7, OP_ADD,   SH_SLL, 0,  16'h0002, 0, 1);
        vecs[23] = alu(4, 5, OP_SUB,   SH_SRL, 15, 16'h0001, 0, 1);

        fork
            monitor();
            begin
                #200000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        rst_n = 1'b0;
        bus.in_valid = 0; bus.ie = 0; bus.we = 0; bus.oe = 0;
        bus.addr_wr = 0; bus.addr_rda = 0; bus.addr_rdb = 0;
        bus.opcode = 0; bus.sh_mode = 0; bus.shamt = 0; bus.inport = 0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_outport", bus.outport, 16'h0000);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_flag_z", bus.flag_z, 1'b0);
        check("rst_flag_c", bus.flag_c, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Load then add with bypass, no bubble.
        send(ld(1, 16'h0005), 1, w);
        send(ld(2, 16'h0003), 1, w);
        check("ld_wait", w, 0);
        send(mk(0, 1, 1, 3, 1, 2, OP_ADD, SH_SLL, 1, 0, 16'h0010, 0, 0), 1, w);
        check("add_wait", w, 0);
        idle();
        @(posedge clk);
        #1;
        check("add_latency_outport", bus.outport, 16'h0010);
        check("add_latency_valid", bus.out_valid, 1'b1);

        for (int i = 0; i < 24; i++) begin
            send(vecs[i], 1, w);
            check("vec_wait", w, 0);
        end
        idle();
        repeat (3) @(posedge clk);
        #1;

        // Back-pressure: second oe instruction stalls in W.
        bus.out_ready = 1'b0;
        send(mk(1, 0, 1, 0, 0, 0, OP_ADD, SH_SLL, 0, 16'h1111, 16'h1111, 0, 0), 1, w);
        send(mk(1, 0, 1, 0, 0, 0, OP_ADD, SH_SLL, 0, 16'h2222, 16'h2222, 0, 0), 1, w);
        check("bp_second_wait", w, 0);
        idle();
        check("bp_outport_first", bus.outport, 16'h1111);
        check("bp_out_valid", bus.out_valid, 1'b1);
        check("bp_in_ready_low", bus.in_ready, 1'b0);
        @(posedge clk);
        #1;
        check("bp_in_ready_held", bus.in_ready, 1'b0);
        check("bp_outport_held", bus.outport, 16'h1111);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_outport_second", bus.outport, 16'h2222);
        check("bp_valid_stays", bus.out_valid, 1'b1);
        check("bp_in_ready_back", bus.in_ready, 1'b1);

        // we-only instructions flow at full rate while the outport is blocked.
        send(ld(1, 16'hAAAA), 1, w);
        check("nb_wait0", w, 0);
        send(ld(2, 16'h5555), 1, w);
        check("nb_wait1", w, 0);
        send(mk(0, 1, 0, 3, 1, 2, OP_ADD, SH_SLL, 0, 0, 0, 0, 0), 1, w);
        check("nb_wait2", w, 0);
        idle();
        @(posedge clk);
        #1;
        check("nb_outport_unchanged", bus.outport, 16'h2222);
        check("nb_valid_held", bus.out_valid, 1'b1);
        bus.out_ready = 1'b1;
        send(alu(3, 0, OP_PASSA, SH_SLL, 0, 16'hFFFF, 0, 0), 1, w);
        send(alu(1, 0, OP_PASSA, SH_SLL, 0, 16'hAAAA, 0, 0), 1, w);
        idle();
        repeat (3) @(posedge clk);
        #1;

        // Reset with W occupied and an unconsumed result on the outport.
        bus.out_ready = 1'b0;
        send(ld(3, 16'h1234), 0, w);
        send(mk(0, 0, 1, 0, 7, 7, OP_ADD, SH_SLL, 0, 0, 0, 0, 0), 0, w);
        send(mk(1, 0, 1, 0, 0, 0, OP_ADD, SH_SLL, 0, 16'h4321, 0, 0, 0), 0, w);
        idle();
        check("pre_rst_outport", bus.outport, 16'h0002);
        check("pre_rst_flag_c", bus.flag_c, 1'b1);
        check("pre_rst_in_ready", bus.in_ready, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outport", bus.outport, 16'h0000);
        check("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_flag_z", bus.flag_z, 1'b0);
        check("mid_rst_flag_c", bus.flag_c, 1'b0);
        check("mid_rst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(alu(3, 0, OP_PASSA, SH_SLL, 0, 16'h0000, 1, 0), 1, w);
        idle();
        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
